// File: rtl/button_input_bank.sv
// button_input_bank: per-channel pin synchroniser, counter debounce,
// press/release pulses, one-shot long-press and optional toggle latch.
module button_input_bank #(
    parameter int unsigned       NUM_CH            = 4,
    parameter int unsigned       DEBOUNCE_CYCLES   = 1_000_000,
    parameter int unsigned       LONG_PRESS_CYCLES = 50_000_000,
    parameter bit                ACTIVE_LOW        = 1'b0,
    parameter logic [NUM_CH-1:0] TOGGLE_MASK       = '0
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ButtonIn,
    output logic [NUM_CH-1:0] LevelOut,
    output logic [NUM_CH-1:0] ButtonOut,
    output logic [NUM_CH-1:0] PressPulse,
    output logic [NUM_CH-1:0] ReleasePulse,
    output logic [NUM_CH-1:0] LongPress
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HW = $clog2(LONG_PRESS_CYCLES);

    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } lp_state_e;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch

        logic            meta_q;
        logic            sync_q;
        logic            s;
        logic            level_q;
        logic            level_d;
        logic [DW-1:0]   cnt_q;
        logic [DW-1:0]   cnt_d;
        logic            press_q;
        logic            press_d;
        logic            rel_q;
        logic            rel_d;
        logic            tog_q;
        logic            tog_d;
        lp_state_e       st_q;
        lp_state_e       st_d;
        logic [HW-1:0]   hold_q;
        logic [HW-1:0]   hold_d;
        logic            long_q;
        logic            long_d;

        // Polarity is applied after the second flop so both flops
        // reset to the electrical "released" level of the pin.
        assign s = sync_q ^ ACTIVE_LOW;

        // Two-flop synchroniser for the asynchronous pin.
        always_ff @(posedge CLOCK_50) begin
            if (reset) begin
                meta_q <= ACTIVE_LOW;
                sync_q <= ACTIVE_LOW;
            end else begin
                meta_q <= ButtonIn[i];
                sync_q <= meta_q;
            end
        end

        // Debounce: count consecutive mismatched cycles, flip at terminal.
        always_comb begin
            level_d = level_q;
            cnt_d   = '0;
            press_d = 1'b0;
            rel_d   = 1'b0;
            if (s != level_q) begin
                if (cnt_q == DB_LAST) begin
                    level_d = s;
                    press_d = s;
                    rel_d   = ~s;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
        end

        // Toggle latch inverts on every accepted press when enabled.
        always_comb begin
            tog_d = tog_q;
            if (TOGGLE_MASK[i] && press_d) begin
                tog_d = ~tog_q;
            end
        end

        // Long-press FSM: release on the terminal cycle suppresses the pulse.
        always_comb begin
            st_d   = st_q;
            hold_d = hold_q;
            long_d = 1'b0;
            unique case (st_q)
                ST_IDLE: begin
                    if (press_d) begin
                        st_d   = ST_HELD;
                        hold_d = '0;
                    end
                end
                ST_HELD: begin
                    if (rel_d) begin
                        st_d = ST_IDLE;
                    end else if (hold_q == HOLD_LAST) begin
                        st_d   = ST_LONG;
                        long_d = 1'b1;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
                ST_LONG: begin
                    if (rel_d) begin
                        st_d = ST_IDLE;
                    end
                end
                default: begin
                    st_d = ST_IDLE;
                end
            endcase
        end

        // Debounce, pulse and toggle state registers.
        always_ff @(posedge CLOCK_50) begin
            if (reset) begin
                level_q <= 1'b0;
                cnt_q   <= '0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                tog_q   <= 1'b0;
            end else begin
                level_q <= level_d;
                cnt_q   <= cnt_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                tog_q   <= tog_d;
            end
        end

        // Long-press FSM state, hold counter and pulse register.
        always_ff @(posedge CLOCK_50) begin
            if (reset) begin
                st_q   <= ST_IDLE;
                hold_q <= '0;
                long_q <= 1'b0;
            end else begin
                st_q   <= st_d;
                hold_q <= hold_d;
                long_q <= long_d;
            end
        end

        assign LevelOut[i]     = level_q;
        assign ButtonOut[i]    = TOGGLE_MASK[i] ? tog_q : level_q;
        assign PressPulse[i]   = press_q;
        assign ReleasePulse[i] = rel_q;
        assign LongPress[i]    = long_q;

    end

endmodule

// File: tb/tb_button_input_bank.sv
// tb_button_input_bank: directed and random pin activity against a
// window-based reference model, compared every cycle via a scoreboard.
module tb_button_input_bank;

    localparam int NCH = 4;
    localparam int DB  = 8;
    localparam int LP  = 32;
    localparam logic [3:0] TMASK = 4'b0010;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] pins  = 4'b0000;
    logic [3:0] LevelOut;
    logic [3:0] ButtonOut;
    logic [3:0] PressPulse;
    logic [3:0] ReleasePulse;
    logic [3:0] LongPress;

    typedef struct {
        int         cyc;
        logic [3:0] lvl;
        logic [3:0] btn;
        logic [3:0] pp;
        logic [3:0] rp;
        logic [3:0] lp;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;

    bit         pq[NCH][$];
    bit         win[NCH][$];
    logic [3:0] m_lvl;
    logic [3:0] m_tog;
    int         press_t[NCH];

    button_input_bank #(
        .NUM_CH(4),
        .DEBOUNCE_CYCLES(8),
        .LONG_PRESS_CYCLES(32),
        .ACTIVE_LOW(1'b0),
        .TOGGLE_MASK(4'b0010)
    ) dut (
        .CLOCK_50(clk),
        .reset(reset),
        .ButtonIn(pins),
        .LevelOut(LevelOut),
        .ButtonOut(ButtonOut),
        .PressPulse(PressPulse),
        .ReleasePulse(ReleasePulse),
        .LongPress(LongPress)
    );

    initial forever #5 clk = ~clk;

    // Reference: a level is accepted once the last DB synchronised
    // samples since the previous change all disagree with it.
    always @(posedge clk) begin
        exp_t e;
        logic [3:0] pp;
        logic [3:0] rp;
        logic [3:0] lp;
        cyc++;
        pp = '0;
        rp = '0;
        lp = '0;
        if (reset) begin
            m_lvl = '0;
            m_tog = '0;
            for (int c = 0; c < NCH; c++) begin
                pq[c].delete();
                pq[c].push_back(1'b0);
                pq[c].push_back(1'b0);
                win[c].delete();
                press_t[c] = -1000000;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                bit s;
                bit all_diff;
                pq[c].push_back(pins[c]);
                s = pq[c].pop_front();
                win[c].push_back(s);
                if (win[c].size() > DB) win[c].delete(0);
                all_diff = (win[c].size() == DB);
                for (int k = 0; k < win[c].size(); k++) begin
                    if (win[c][k] == m_lvl[c]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_lvl[c] = ~m_lvl[c];
                    win[c].delete();
                    if (m_lvl[c]) begin
                        pp[c] = 1'b1;
                        press_t[c] = cyc;
                        if (TMASK[c]) m_tog[c] = ~m_tog[c];
                    end else begin
                        rp[c] = 1'b1;
                    end
                end
                if (m_lvl[c] && !pp[c] && (cyc - press_t[c] == LP)) begin
                    lp[c] = 1'b1;
                end
            end
        end
        e.cyc = cyc;
        e.lvl = m_lvl;
        e.btn = (m_lvl & ~TMASK) | (m_tog & TMASK);
        e.pp  = pp;
        e.rp  = rp;
        e.lp  = lp;
        sb.push_back(e);
    end

    task automatic chk(input string nm, input int c,
                       input logic [3:0] got, input logic [3:0] want);
        n_chk++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle %0d: got %b expected %b",
                     nm, c, got, want);
        end
    endtask

    // Monitor: pop one expected snapshot per cycle, away from the edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("LevelOut", e.cyc, LevelOut, e.lvl);
            chk("ButtonOut", e.cyc, ButtonOut, e.btn);
            chk("PressPulse", e.cyc, PressPulse, e.pp);
            chk("ReleasePulse", e.cyc, ReleasePulse, e.rp);
            chk("LongPress", e.cyc, LongPress, e.lp);
        end
    end

    task automatic drive(input logic [3:0] p, input int n);
        pins = p;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        drive(4'b0000, 5);

        // clean press/release on ch0
        drive(4'b0001, 20);
        drive(4'b0000, 20);

        // ch0 bounces every 3 cycles, then settles high
        for (int k = 0; k < 10; k++) begin
            drive((k % 2 == 0) ? 4'b0001 : 4'b0000, 3);
        end
        drive(4'b0001, 20);
        drive(4'b0000, 20);

        // ch3 long hold
        drive(4'b1000, 70);
        drive(4'b0000, 20);

        // ch1 toggle twice
        drive(4'b0010, 20);
        drive(4'b0000, 20);
        drive(4'b0010, 20);
        drive(4'b0000, 20);

        // all channels together, held past long-press
        drive(4'b1111, 50);
        drive(4'b0000, 20);

        // reset while ch2 is held
        drive(4'b0100, 20);
        pulse_reset();
        drive(4'b0100, 20);
        drive(4'b0000, 20);

        // release just before, exactly at, and just after terminal
        drive(4'b0001, 31);
        drive(4'b0000, 20);
        drive(4'b0001, 32);
        drive(4'b0000, 20);
        drive(4'b0001, 33);
        drive(4'b0000, 20);

        // random activity with occasional resets
        for (int s = 0; s < 150; s++) begin
            logic [3:0] flips;
            if ($urandom_range(0, 39) == 0) pulse_reset();
            flips = 4'($urandom_range(0, 15));
            drive(pins ^ flips, $urandom_range(1, 45));
        end
        drive(4'b0000, 60);

        @(negedge clk);
        #1;
        n_chk++;
        if (sb.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain: got %0d left expected 0",
                     sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
